data_mem_resp: RTL

- Responder end of the load/store data-memory interface driven by the AGU.
- Accepts one word-sized load or store per cycle and holds a word-addressed data RAM.
- Returns load data, tagged with the issuing tag, after a fixed pipeline latency, for broadcast on the CDB.
- Back-pressure from the CDB arbiter freezes the pipeline and deasserts req_ready.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/data_ram.sv | 44 ++++
 rtl/data_mem_resp.sv | 117 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared load/store data-memory request/response types and widths.
// Revision : 1.0
// ============================================================================
package mem_pkg;

   localparam int c_DATA_W = 32;
   localparam int c_TAG_W  = 6;

   typedef struct packed {
      logic                  we;
      logic [31:0]           addr;
      logic [c_DATA_W-1:0]   wdata;
      logic [c_TAG_W-1:0]    tag;
   } mem_req_t;

   typedef struct packed {
      logic [c_DATA_W-1:0]   data;
      logic [c_TAG_W-1:0]    tag;
      logic                  err;
   } mem_rsp_t;

endpackage
`default_nettype wire

// File: rtl/data_ram.sv
`default_nettype none
// ============================================================================
// Module   : data_ram
// Brief    : Single-port word RAM, synchronous write, registered read.
// Revision : 1.0
// ============================================================================
module data_ram
   import mem_pkg::*;
#(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10,
   parameter int DATA_W = c_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // Storage is never reset; only the read register is.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_resp
// Brief    : Data-memory responder: RAM plus fixed-latency tagged load pipeline.
// Revision : 1.0
// ============================================================================
module data_mem_resp
   import mem_pkg::*;
#(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10,
   parameter int RD_LAT = 2,
   parameter int TAG_W  = c_TAG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   input  logic [TAG_W-1:0] req_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_err
);

   logic              w_adv;
   logic              w_acc;
   logic              w_bad;
   logic              w_ld;
   logic              w_st;
   logic [ADDR_W-1:0] w_idx;
   logic [31:0]       w_ram_rdata;
   logic [31:0]       w_s1_data;
   logic [31:0]       w_out_data;

   logic [RD_LAT-1:0] r_v;
   logic [RD_LAT-1:0] r_err;
   logic [TAG_W-1:0]  r_tag [RD_LAT];

   assign w_adv     = !rsp_valid | rsp_ready;
   assign req_ready = w_adv;
   assign w_acc     = req_valid & w_adv;
   assign w_bad     = (|req_addr[1:0]) | (|req_addr[31:ADDR_W+2]);
   assign w_idx     = req_addr[ADDR_W+1:2];
   assign w_ld      = w_acc & !req_we;
   assign w_st      = w_acc & req_we & !w_bad;

   // Read register advances with the pipeline so stalled data stays put.
   data_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (32)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_st),
      .i_re    (w_adv),
      .i_addr  (w_idx),
      .i_wdata (req_wdata),
      .o_rdata (w_ram_rdata)
   );

   assign w_s1_data = r_err[0] ? 32'd0 : w_ram_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v   <= '0;
         r_err <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            r_tag[i] <= '0;
         end
      end else if (w_adv) begin
         r_v[0]   <= w_ld;
         r_err[0] <= w_ld & w_bad;
         r_tag[0] <= req_tag;
         for (int i = 1; i < RD_LAT; i++) begin
            r_v[i]   <= r_v[i-1];
            r_err[i] <= r_err[i-1];
            r_tag[i] <= r_tag[i-1];
         end
      end
   end

   generate
      if (RD_LAT == 1) begin : g_lat1
         assign w_out_data = w_s1_data;
      end else begin : g_latn
         logic [31:0] r_data [1:RD_LAT-1];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 1; i < RD_LAT; i++) begin
                  r_data[i] <= '0;
               end
            end else if (w_adv) begin
               r_data[1] <= w_s1_data;
               for (int i = 2; i < RD_LAT; i++) begin
                  r_data[i] <= r_data[i-1];
               end
            end
         end

         assign w_out_data = r_data[RD_LAT-1];
      end
   endgenerate

   assign rsp_valid = r_v[RD_LAT-1];
   assign rsp_err   = r_err[RD_LAT-1];
   assign rsp_tag   = r_tag[RD_LAT-1];
   assign rsp_data  = w_out_data;

endmodule
`default_nettype wire
